// File: rtl/prng_ctrl_pkg.sv
// Shared types and helpers for the LFSR generator sequencing controller.
// Holds the state encoding, default widths and the phase-selection rule.
package prng_ctrl_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int RND_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XOR,
        SHIFT,
        DONE
    } state_t;

    // First active phase of a round: XOR if any, else SHIFT if any, else straight to DONE.
    function automatic state_t next_phase(input logic xor_nz, input logic shift_nz);
        if (xor_nz) begin
            return XOR;
        end
        if (shift_nz) begin
            return SHIFT;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/prng_phase_counter.sv
// Loadable down-counter that times the XOR and SHIFT phases.
// Load wins over decrement; zero flags the last cycle of a phase.
module prng_phase_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/prng_seq_controller.sv
// Sequencing FSM for the LFSR generator: LOAD, XOR-mix and SHIFT strobes with
// programmable phase lengths, continuous mode, abort and a round counter.
module prng_seq_controller
    import prng_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cont,
    input  logic [CNT_W-1:0] xor_len,
    input  logic [CNT_W-1:0] shift_len,
    output logic             load,
    output logic             xor_en,
    output logic             shift_en,
    output logic             done,
    output logic             busy,
    output logic [RND_W-1:0] round_cnt
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] xor_len_reg, shift_len_reg;
    logic [RND_W-1:0] round_cnt_reg;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_count;
    logic             latch_lens, rnd_clr, rnd_inc;
    state_t           round_phase;
    logic [CNT_W-1:0] round_first_val;

    prng_phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .dec     (cnt_dec),
        .count   (cnt_count),
        .zero    (cnt_zero)
    );

    // Entry into a round (from LOAD, or from DONE in continuous mode) uses the latched lengths.
    always_comb begin
        round_phase     = next_phase(xor_len_reg != '0, shift_len_reg != '0);
        round_first_val = (round_phase == XOR) ? (xor_len_reg - CNT_W'(1))
                                               : (shift_len_reg - CNT_W'(1));
    end

    always_comb begin
        state_next = state_reg;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        latch_lens = 1'b0;
        rnd_clr    = 1'b0;
        rnd_inc    = 1'b0;

        if (abort && state_reg != IDLE) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        state_next = LOAD;
                        latch_lens = 1'b1;
                        rnd_clr    = 1'b1;
                    end
                end
                LOAD: begin
                    state_next = round_phase;
                    cnt_load   = (round_phase != DONE);
                    cnt_val    = round_first_val;
                end
                XOR: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (shift_len_reg != '0) begin
                        state_next = SHIFT;
                        cnt_load   = 1'b1;
                        cnt_val    = shift_len_reg - CNT_W'(1);
                    end else begin
                        state_next = DONE;
                    end
                end
                SHIFT: begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    rnd_inc = 1'b1;
                    if (cont) begin
                        state_next = round_phase;
                        cnt_load   = (round_phase != DONE);
                        cnt_val    = round_first_val;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            xor_len_reg   <= '0;
            shift_len_reg <= '0;
            round_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_lens) begin
                xor_len_reg   <= xor_len;
                shift_len_reg <= shift_len;
            end
            if (rnd_clr) begin
                round_cnt_reg <= '0;
            end else if (rnd_inc) begin
                round_cnt_reg <= round_cnt_reg + RND_W'(1);
            end
        end
    end

    assign load      = (state_reg == LOAD);
    assign xor_en    = (state_reg == XOR);
    assign shift_en  = (state_reg == SHIFT);
    assign done      = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign round_cnt = round_cnt_reg;

endmodule

// File: doc/prng_seq_controller.md
Name: prng_seq_controller

Overview:
- Parametrised sequencing controller for the LFSR-based random generator datapath. Drives the load, XOR-mix and shift-enable strobes.
- Successor to the fixed-sequence generator controller. Adds these over the fixed version:
  - runtime-programmable XOR phase count and shift count, with an internal counter instead of an external shift counter;
  - a continuous (free-running) mode;
  - abort;
  - a busy flag and a round counter.
- Sits between the top-level command logic and the generator datapath.

Parameters:
- CNT_W, 4, width of the xor_len/shift_len inputs and of the internal phase counter.
- RND_W, 8, width of the round_cnt output.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- abort  input  1  synchronous abort; highest priority after rst.
- cont  input  1  continuous mode; sampled in DONE.
- xor_len  input  CNT_W  number of XOR cycles per round; latched on accepted start.
- shift_len  input  CNT_W  number of shift cycles per round; latched on accepted start.
- load  output  1  seed-load strobe to datapath.
- xor_en  output  1  XOR-mix enable.
- shift_en  output  1  shift enable.
- done  output  1  one-cycle end-of-round pulse.
- busy  output  1  high in every state except IDLE.
- round_cnt  output  RND_W  completed rounds since last accepted start.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE;
  - load, xor_en, shift_en, done and busy are 0;
  - round_cnt and the phase counter are 0;
  - the latched lengths are 0.
- States: IDLE, LOAD, XOR, SHIFT, DONE. The encoding is a package enum.
- All outputs are Moore, decoded from the registered state:
  - load = LOAD;
  - xor_en = XOR;
  - shift_en = SHIFT;
  - done = DONE;
  - busy = not IDLE.
- IDLE:
  - start=1 goes to LOAD.
  - On the same edge, latch xor_len and shift_len, and clear round_cnt.
  - start=0 stays in IDLE.
- LOAD: exactly 1 cycle, then:
  - if the latched xor_len != 0, go to XOR with counter = xor_len-1;
  - else if the latched shift_len != 0, go to SHIFT with counter = shift_len-1;
  - else go to DONE.
- XOR:
  - counter != 0: decrement the counter and stay in XOR.
  - counter == 0: go to SHIFT (counter = shift_len-1) if shift_len != 0, else go to DONE.
- SHIFT:
  - counter != 0: decrement the counter and stay in SHIFT.
  - counter == 0: go to DONE.
- DONE: exactly 1 cycle; round_cnt increments on exit and wraps modulo 2^RND_W.
  - cont=1: start a new round without reload. The next state is XOR/SHIFT/DONE with the same selection rule as LOAD, using the latched lengths.
  - cont=0: go to IDLE.
- Timing for a start accepted at edge 0 with X = xor_len and S = shift_len:
  - load is high in cycle 1;
  - xor_en is high in cycles 2..X+1;
  - shift_en is high in cycles X+2..X+S+1;
  - done is high in cycle X+S+2.
  - Continuous rounds repeat with period X+S+1 cycles.
- Zero lengths:
  - X=S=0 gives LOAD then DONE; done is high in cycle 2.
  - In continuous mode with X=S=0, the controller stays in DONE: done is high every cycle and round_cnt increments every cycle.
- Abort:
  - abort=1 in any non-IDLE state goes to IDLE on the next edge.
  - No done pulse is produced, and round_cnt holds its value.
  - abort in IDLE has no effect, and takes priority over start on the same edge.
- start while busy is ignored. It is not queued.
- Input changes while busy: xor_len and shift_len have no effect until the next accepted start.
- rst mid-sequence returns to IDLE on that edge with every output at its reset value.
- At most one of load, xor_en, shift_en and done is high in any cycle.

Decomposition:
- Package prng_ctrl_pkg holds:
  - the state enum type (IDLE, LOAD, XOR, SHIFT, DONE);
  - the default CNT_W and RND_W constants;
  - the next-phase selection function that picks XOR, SHIFT or DONE from the two lengths.
- One sub-module, prng_phase_counter: a CNT_W loadable down-counter with load, dec and a zero flag, instantiated once.
- The FSM and round counter stay in the top module.

Test Plan:
- Reset then start with xor_len=2, shift_len=3, cont=0 -> load in cycle 1; xor_en in cycles 2-3; shift_en in cycles 4-6; done in cycle 7; busy low in cycle 8; round_cnt=1.
- xor_len=0, shift_len=4 -> LOAD goes directly to SHIFT; shift_en in cycles 2-5; done in cycle 6. Then xor_len=0, shift_len=0 -> done in cycle 2.
- cont=1, xor_len=1, shift_len=2 -> done every 4 cycles with no load after the first. Drop cont after the third done -> IDLE; round_cnt=3.
- Abort in the 2nd SHIFT cycle (xor_len=1, shift_len=5) -> IDLE on the next edge; no done pulse; round_cnt unchanged. Also: start and abort together in IDLE -> stays in IDLE.
- start pulsed and xor_len/shift_len changed while busy -> no restart, original timing kept. rst asserted mid-XOR -> all outputs 0 on the next cycle.
- RND_W=2 build, continuous run of 5 rounds -> round_cnt sequence 1,2,3,0,1. The assertion that at most one strobe is high holds throughout every scenario.
